// File: rtl/key_repeat_sched.sv
// Typematic scheduler: held keys -> press/auto-repeat events in a FWFT FIFO (repeats only with TYPEMATIC_EN).
// Latency: push on the first edge a new key is seen, evt_valid the cycle after.
// Backpressure: evt_valid/evt_ready; a push into a full FIFO without a pop is dropped and sets sticky ovf.
module key_repeat_sched #(
  parameter int               DEPTH     = 8,
  parameter int               CNT_W     = 24,
  parameter logic [CNT_W-1:0] DELAY_CYC = 24'd5000000,
  parameter logic [CNT_W-1:0] RATE_CYC  = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             key,
  input  logic                   ctrl,
  input  logic                   alt,
  input  logic                   shift,
  input  logic                   caps,
  input  logic                   clr,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [12:0]            evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

`ifdef TYPEMATIC_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic [CNT_W-1:0] DELAY_LAST = DELAY_CYC - 1'b1;
  localparam logic [CNT_W-1:0] RATE_LAST  = RATE_CYC - 1'b1;
  logic [CNT_W-1:0] cnt, cnt_nx;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
  logic unused_cfg;
  assign unused_cfg = ^{DELAY_CYC, RATE_CYC};
`endif

  state_t        state, state_nx;
  logic [7:0]    key_q;
  logic          new_key, push, rpt, pop, do_push;
  logic [12:0]   evt_in;
  logic [12:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign new_key   = (key != 8'd0) && (key != key_q);
  assign evt_in    = {rpt, ctrl, alt, shift, caps, key};
  assign evt_valid = (evt_count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 13'd0;
  assign pop       = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_push   = push && ((evt_count != FULL) || pop);

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    rpt      = 1'b0;
`ifdef TYPEMATIC_EN
    cnt_nx   = cnt;
`endif
    if (clr) begin
      state_nx = (key != 8'd0) ? HOLD : IDLE;
`ifdef TYPEMATIC_EN
      cnt_nx   = '0;
`endif
    end else if (new_key) begin
      push     = 1'b1;
      state_nx = HOLD;
`ifdef TYPEMATIC_EN
      cnt_nx   = '0;
`endif
    end else if (key == 8'd0) begin
      state_nx = IDLE;
`ifdef TYPEMATIC_EN
      cnt_nx   = '0;
`endif
    end else begin
      case (state)
        IDLE: state_nx = HOLD;
`ifdef TYPEMATIC_EN
        HOLD: begin
          if (cnt == DELAY_LAST) begin
            push     = 1'b1;
            rpt      = 1'b1;
            cnt_nx   = '0;
            state_nx = REPEAT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (cnt == RATE_LAST) begin
            push   = 1'b1;
            rpt    = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      ovf       <= 1'b0;
`ifdef TYPEMATIC_EN
      cnt       <= '0;
`endif
    end else begin
      state <= state_nx;
      key_q <= key;
`ifdef TYPEMATIC_EN
      cnt   <= cnt_nx;
`endif
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        evt_count <= '0;
        ovf       <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !do_push) ovf <= 1'b1;
        if (do_push && !pop) evt_count <= evt_count + 1'b1;
        else if (pop && !do_push) evt_count <= evt_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= evt_in;
  end
endmodule

// File: tb/tb_key_repeat_sched.sv
// Bench for key_repeat_sched: directed scenarios plus random traffic against a due-time/queue reference model.
module tb_key_repeat_sched;
  localparam int         DEPTH = 4;
  localparam int         CNT_W = 8;
  localparam logic [7:0] DELAY = 8'd10;
  localparam logic [7:0] RATE  = 8'd4;
  localparam int         CW    = $clog2(DEPTH) + 1;
`ifdef TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  typedef logic [CW+14:0] obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        key = 8'd0;
  logic              ctrl = 1'b0, alt = 1'b0, shift = 1'b0, caps = 1'b0;
  logic              clr = 1'b0, evt_ready = 1'b1;
  logic              evt_valid;
  logic [12:0]       evt_data;
  logic [CW-1:0]     evt_count;
  logic              ovf;

  key_repeat_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DELAY_CYC(DELAY), .RATE_CYC(RATE)) dut (
    .clk(clk), .rst(rst), .key(key), .ctrl(ctrl), .alt(alt), .shift(shift), .caps(caps),
    .clr(clr), .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_count(evt_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int t = 0;

  // Reference model: event queue, sticky drop flag, last key, and the absolute edge of the next repeat.
  logic [12:0] mq[$];
  bit          m_ovf = 1'b0;
  logic [7:0]  m_keyq = 8'd0;
  bit          m_active = 1'b0;
  int          m_due = 0;

  logic [12:0] dut_log[$];
  int          dut_t[$];

  function automatic obs_t m_out();
    logic [12:0] h;
    h = (mq.size() > 0) ? mq[0] : 13'd0;
    return {mq.size() > 0, h, CW'(mq.size()), m_ovf};
  endfunction

  task automatic step();
    bit          push, pop, rb;
    logic [12:0] ev;
    if (evt_valid === 1'b1 && evt_ready) begin
      dut_log.push_back(evt_data);
      dut_t.push_back(t);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_keyq   = 8'd0;
      m_active = 1'b0;
    end else begin
      push = 1'b0;
      rb   = 1'b0;
      pop  = (mq.size() > 0) && evt_ready;
      if (clr) begin
        mq.delete();
        m_ovf    = 1'b0;
        pop      = 1'b0;
        m_active = (key != 8'd0);
        m_due    = t + int'(DELAY);
      end else if (key != 8'd0 && key != m_keyq) begin
        push     = 1'b1;
        m_active = 1'b1;
        m_due    = t + int'(DELAY);
      end else if (key == 8'd0) begin
        m_active = 1'b0;
      end else if (TYP && m_active && t == m_due) begin
        push  = 1'b1;
        rb    = 1'b1;
        m_due = t + int'(RATE);
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        ev = {rb, ctrl, alt, shift, caps, key};
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1'b1;
      end
      m_keyq = key;
    end
    t++;
    #1;
  endtask

  task automatic test_reset();
    obs_t exp;
    rst = 1'b1; key = 8'h33; shift = 1'b1; evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== '0) begin
        $display("FAIL reset_outputs: got %h want 0", {evt_valid, evt_data, evt_count, ovf});
      end else passes++;
    end
    rst = 1'b0; key = 8'd0; shift = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp)
        $display("FAIL reset_idle t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      else passes++;
    end
  endtask

  task automatic test_hold_repeat();
    obs_t exp;
`ifdef TYPEMATIC_EN
    logic [12:0] ed[$] = '{13'h21C, 13'h121C, 13'h121C, 13'h121C};
    int          eo[$] = '{0, 10, 14, 18};
`else
    logic [12:0] ed[$] = '{13'h21C};
    int          eo[$] = '{0};
`endif
    dut_log.delete(); dut_t.delete();
    evt_ready = 1'b1; key = 8'h1C; shift = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 20) begin key = 8'd0; shift = 1'b0; end
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp)
        $display("FAIL hold t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      else passes++;
    end
    checks++;
    if (dut_log.size() != ed.size())
      $display("FAIL hold_event_count: got %0d want %0d", dut_log.size(), ed.size());
    else passes++;
    for (int i = 0; i < ed.size() && i < dut_log.size(); i++) begin
      checks++;
      if (dut_log[i] !== ed[i] || dut_t[i] - dut_t[0] != eo[i])
        $display("FAIL hold_event%0d: got %h at +%0d want %h at +%0d", i, dut_log[i], dut_t[i] - dut_t[0], ed[i], eo[i]);
      else passes++;
    end
  endtask

  task automatic test_key_change();
    obs_t exp;
`ifdef TYPEMATIC_EN
    logic [12:0] ed[$] = '{13'h01C, 13'h032, 13'h132, 13'h132};
    int          eo[$] = '{0, 5, 15, 19};
`else
    logic [12:0] ed[$] = '{13'h01C, 13'h032};
    int          eo[$] = '{0, 5};
`endif
    dut_log.delete(); dut_t.delete();
    evt_ready = 1'b1; key = 8'h1C;
    for (int i = 0; i < 28; i++) begin
      if (i == 5) key = 8'h32;
      if (i == 21) key = 8'd0;
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp)
        $display("FAIL key_change t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      else passes++;
    end
    checks++;
    if (dut_log.size() != ed.size())
      $display("FAIL key_change_event_count: got %0d want %0d", dut_log.size(), ed.size());
    else passes++;
    for (int i = 0; i < ed.size() && i < dut_log.size(); i++) begin
      checks++;
      if (dut_log[i] !== ed[i] || dut_t[i] - dut_t[0] != eo[i])
        $display("FAIL key_change_event%0d: got %h at +%0d want %h at +%0d", i, dut_log[i], dut_t[i] - dut_t[0], ed[i], eo[i]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [12:0] want;
    obs_t        exp;
    dut_log.delete(); dut_t.delete();
    evt_ready = 1'b0; key = 8'd0;
    for (int i = 0; i < 7; i++) begin
      key = (i < 6) ? 8'(8'h11 + i) : 8'd0;
      step();
    end
    checks++;
    if (evt_count !== 3'd4 || ovf !== 1'b1 || evt_data !== 13'h011)
      $display("FAIL overflow_full: got count=%0d ovf=%b head=%h want count=4 ovf=1 head=011", evt_count, ovf, evt_data);
    else passes++;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp)
        $display("FAIL overflow_drain t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      else passes++;
    end
    checks++;
    if (dut_log.size() != 4) $display("FAIL overflow_drain_count: got %0d want 4", dut_log.size());
    else passes++;
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
      want = 13'(13'h011 + i);
      checks++;
      if (dut_log[i] !== want) $display("FAIL overflow_order%0d: got %h want %h", i, dut_log[i], want);
      else passes++;
    end
    evt_ready = 1'b0;
    key = 8'h61; step();
    key = 8'h62; step();
    key = 8'd0; clr = 1'b1; step();
    clr = 1'b0;
    checks++;
    if (evt_count !== 3'd0 || ovf !== 1'b0 || evt_valid !== 1'b0)
      $display("FAIL clr: got count=%0d ovf=%b valid=%b want 0 0 0", evt_count, ovf, evt_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    key = 8'd0; evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key = 8'(8'h21 + i);
      step();
    end
    key = 8'h25; evt_ready = 1'b1;
    step();
    checks++;
    if (evt_count !== 3'd4 || ovf !== 1'b0 || evt_data !== 13'h022)
      $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h want count=4 ovf=0 head=022", evt_count, ovf, evt_data);
    else passes++;
    dut_log.delete(); dut_t.delete();
    key = 8'd0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (dut_log.size() != 4 || dut_log[dut_log.size()-1] !== 13'h025)
      $display("FAIL full_push_pop_tail: got %0d events last %h want 4 events last 025", dut_log.size(),
               (dut_log.size() > 0) ? dut_log[dut_log.size()-1] : 13'h0);
    else passes++;
  endtask

  task automatic test_rst_mid_repeat();
    obs_t exp;
`ifdef TYPEMATIC_EN
    logic [12:0] ed[$] = '{13'h040, 13'h140};
    int          eo[$] = '{0, 10};
`else
    logic [12:0] ed[$] = '{13'h040};
    int          eo[$] = '{0};
`endif
    evt_ready = 1'b1; key = 8'h40;
    for (int i = 0; i < 14; i++) step();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({evt_valid, evt_data, evt_count, ovf} !== '0)
      $display("FAIL rst_mid_repeat: got %h want 0", {evt_valid, evt_data, evt_count, ovf});
    else passes++;
    dut_log.delete(); dut_t.delete();
    rst = 1'b0;
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_data !== 13'h040)
      $display("FAIL rst_press: got valid=%b data=%h want 1 040", evt_valid, evt_data);
    else passes++;
    for (int i = 0; i < 14; i++) begin
      if (i == 12) key = 8'd0;
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp)
        $display("FAIL rst_hold t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      else passes++;
    end
    checks++;
    if (dut_log.size() != ed.size())
      $display("FAIL rst_event_count: got %0d want %0d", dut_log.size(), ed.size());
    else passes++;
    for (int i = 0; i < ed.size() && i < dut_log.size(); i++) begin
      checks++;
      if (dut_log[i] !== ed[i] || dut_t[i] - dut_t[0] != eo[i])
        $display("FAIL rst_event%0d: got %h at +%0d want %h at +%0d", i, dut_log[i], dut_t[i] - dut_t[0], ed[i], eo[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    obs_t exp;
    int   bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: key = 8'd0;
          1: key = 8'h1C;
          2: key = 8'h32;
          default: key = 8'h55;
        endcase
      end
      {ctrl, alt, shift, caps} = 4'($urandom_range(15));
      evt_ready = ($urandom_range(3) != 0);
      clr = ($urandom_range(99) == 0);
      step();
      exp = m_out();
      checks++;
      if ({evt_valid, evt_data, evt_count, ovf} !== exp) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random t=%0d: got %h want %h", t, {evt_valid, evt_data, evt_count, ovf}, exp);
      end else passes++;
    end
    clr = 1'b0; key = 8'd0; {ctrl, alt, shift, caps} = 4'd0; evt_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_key_change();
    test_overflow();
    test_back_to_back();
    test_rst_mid_repeat();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
